// File: rtl/cart_mem_sched_if.sv
// Signal bundle between the cartridge memory scheduler and its download, core and SDRAM neighbours.
// dl_wr is a one-cycle valid and dl_wait its inverted ready; core_rd is a level request answered by a core_valid pulse.
interface cart_mem_sched_if #(
    parameter int ADDR_W  = 25,
    parameter int CORE_AW = 20,
    parameter int MASK_W  = 19
);
    logic               dl_active;
    logic               dl_wr;
    logic [ADDR_W-1:0]  dl_addr;
    logic [7:0]         dl_data;
    logic               dl_wait;
    logic               core_rd;
    logic [CORE_AW-1:0] core_addr;
    logic [7:0]         core_dout;
    logic               core_valid;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic               mem_wr;
    logic [7:0]         mem_din;
    logic [7:0]         mem_dout;
    logic               mem_busy;
    logic [MASK_W-1:0]  rom_mask;
    logic [2:0]         fsm_state;

    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, core_rd, core_addr, mem_dout, mem_busy,
        output dl_wait, core_dout, core_valid, mem_addr, mem_rd, mem_wr, mem_din, rom_mask, fsm_state
    );
    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, core_rd, core_addr, mem_dout, mem_busy,
        input  dl_wait, core_dout, core_valid, mem_addr, mem_rd, mem_wr, mem_din, rom_mask, fsm_state
    );
endinterface

// File: rtl/cart_mem_sched.sv
// Shares SDRAM channel 0 between the HPS ROM download (byte writes) and console ROM fetches
// (byte reads), with a one-entry read cache and a ROM size mask derived from the download.
module cart_mem_sched #(
    parameter int ADDR_W    = 25,
    parameter int CORE_AW   = 20,
    parameter int MASK_W    = 19,
    parameter int GUARD_CYC = 2
) (
    input  logic            clk,
    input  logic            reset,
    cart_mem_sched_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_ISSUE  = 3'd1;
    localparam logic [2:0] RD_ISSUE  = 3'd2;
    localparam logic [2:0] GUARD     = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam int GW = $clog2(GUARD_CYC + 1);

    logic [2:0]         state;
    logic [GW-1:0]      guard_cnt;
    logic               hold_full;
    logic [ADDR_W-1:0]  hold_addr;
    logic [7:0]         hold_data;
    logic               op_rd;
    logic [CORE_AW-1:0] rd_addr;
    logic               cache_valid;
    logic [CORE_AW-1:0] cache_addr;
    logic [7:0]         cache_data;
    logic               mem_rd_q, mem_wr_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [7:0]         mem_din_q;
    logic [7:0]         core_dout_q;
    logic               core_valid_q;
    logic [MASK_W-1:0]  rom_mask_q, max_addr;
    logic               seen_wr, mask_pending, dl_active_q;

    logic [CORE_AW-1:0] masked_addr;
    logic               accept_wr, cache_hit, dl_rise, dl_fall, rd_allowed;

    // Round up to the next 2^n-1 so the mask covers every downloaded byte.
    function automatic logic [MASK_W-1:0] smear(input logic [MASK_W-1:0] x);
        logic [MASK_W-1:0] r;
        r = x;
        for (int i = 1; i < MASK_W; i++) r = r | (x >> i);
        return r;
    endfunction

    assign masked_addr = bus.core_addr & CORE_AW'(rom_mask_q);
    assign accept_wr   = bus.dl_wr & ~hold_full;
    assign cache_hit   = cache_valid & (cache_addr == masked_addr);
    assign dl_rise     = bus.dl_active & ~dl_active_q;
    assign dl_fall     = ~bus.dl_active & dl_active_q;
    // Reads wait for a pending mask update so they never use a stale mask.
    assign rd_allowed  = bus.core_rd & ~bus.dl_active & ~bus.dl_wr & ~mask_pending & ~dl_fall;

    assign bus.dl_wait    = hold_full | ((state != IDLE) & bus.dl_active);
    assign bus.core_dout  = core_dout_q;
    assign bus.core_valid = core_valid_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.rom_mask   = rom_mask_q;
    assign bus.fsm_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            guard_cnt    <= '0;
            hold_full    <= 1'b0;
            hold_addr    <= '0;
            hold_data    <= '0;
            op_rd        <= 1'b0;
            rd_addr      <= '0;
            cache_valid  <= 1'b0;
            cache_addr   <= '0;
            cache_data   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            core_dout_q  <= '0;
            core_valid_q <= 1'b0;
            rom_mask_q   <= '1;
            max_addr     <= '0;
            seen_wr      <= 1'b0;
            mask_pending <= 1'b0;
            dl_active_q  <= 1'b0;
        end else begin
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            core_valid_q <= 1'b0;
            dl_active_q  <= bus.dl_active;

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state      <= WR_ISSUE;
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= hold_addr;
                        mem_din_q  <= hold_data;
                        op_rd      <= 1'b0;
                    end else if (rd_allowed) begin
                        if (cache_hit) begin
                            if (!core_valid_q) begin
                                core_valid_q <= 1'b1;
                                core_dout_q  <= cache_data;
                            end
                        end else begin
                            state      <= RD_ISSUE;
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= ADDR_W'(masked_addr);
                            rd_addr    <= masked_addr;
                            op_rd      <= 1'b1;
                        end
                    end
                end
                WR_ISSUE: begin
                    hold_full <= 1'b0;
                    guard_cnt <= '0;
                    state     <= GUARD;
                end
                RD_ISSUE: begin
                    guard_cnt <= '0;
                    state     <= GUARD;
                end
                GUARD: begin
                    if (guard_cnt == GW'(GUARD_CYC - 1)) state <= WAIT_DONE;
                    else guard_cnt <= guard_cnt + GW'(1);
                end
                WAIT_DONE: begin
                    if (!bus.mem_busy) begin
                        state <= IDLE;
                        if (op_rd) begin
                            core_dout_q  <= bus.mem_dout;
                            cache_addr   <= rd_addr;
                            cache_data   <= bus.mem_dout;
                            cache_valid  <= 1'b1;
                            core_valid_q <= bus.core_rd & ~bus.dl_active & (masked_addr == rd_addr);
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (mask_pending && state == IDLE && !hold_full) begin
                rom_mask_q   <= smear(max_addr);
                mask_pending <= 1'b0;
            end

            // Later assignments override the cache fill above.
            if (accept_wr) begin
                hold_full   <= 1'b1;
                hold_addr   <= bus.dl_addr;
                hold_data   <= bus.dl_data;
                cache_valid <= 1'b0;
            end

            if (dl_rise) begin
                max_addr     <= accept_wr ? bus.dl_addr[MASK_W-1:0] : '0;
                seen_wr      <= accept_wr;
                cache_valid  <= 1'b0;
                mask_pending <= 1'b0;
            end else if (accept_wr && bus.dl_active) begin
                if (bus.dl_addr[MASK_W-1:0] > max_addr) max_addr <= bus.dl_addr[MASK_W-1:0];
                seen_wr <= 1'b1;
            end else if (dl_fall && seen_wr) begin
                mask_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cart_mem_sched.sv
// Directed bench for cart_mem_sched: SDRAM busy model, download, read cache and reset scenarios.
module tb_cart_mem_sched;
  localparam int ADDR_W  = 25;
  localparam int CORE_AW = 20;
  localparam int MASK_W  = 19;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cart_mem_sched_if #(.ADDR_W(ADDR_W), .CORE_AW(CORE_AW), .MASK_W(MASK_W)) bus ();

  cart_mem_sched #(.ADDR_W(ADDR_W), .CORE_AW(CORE_AW), .MASK_W(MASK_W), .GUARD_CYC(2)) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  // SDRAM model state (written only by the model process)
  int busy_len = 4;
  logic [7:0] rd_value = 8'h00;
  int wr_cnt = 0, rd_cnt = 0, valid_cnt = 0, proto_err = 0, cyc = 0;
  int wr_time = 0, rd_time = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  logic [ADDR_W+7:0] obs_q[$];

  initial begin : sdram_model
    int cnt;
    logic prev;
    cnt = 0;
    prev = 1'b0;
    bus.mem_busy = 1'b0;
    bus.mem_dout = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cnt = 0;
        prev = 1'b0;
        bus.mem_busy = 1'b0;
      end else begin
        if (bus.mem_rd && bus.mem_wr) proto_err++;
        if ((bus.mem_rd || bus.mem_wr) && prev) proto_err++;
        prev = bus.mem_rd || bus.mem_wr;
        if (bus.mem_wr) begin
          wr_cnt++;
          wr_time = cyc;
          obs_q.push_back({bus.mem_addr, bus.mem_din});
        end
        if (bus.mem_rd) begin
          rd_cnt++;
          rd_time = cyc;
          last_rd_addr = bus.mem_addr;
          bus.mem_dout = rd_value;
        end
        if (bus.mem_rd || bus.mem_wr) begin
          cnt = busy_len;
          bus.mem_busy = 1'b1;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) bus.mem_busy = 1'b0;
        end
        if (bus.core_valid) valid_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.dl_active = 1'b0;
    bus.dl_wr = 1'b0;
    bus.dl_addr = '0;
    bus.dl_data = '0;
    bus.core_rd = 1'b0;
    bus.core_addr = '0;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic dl_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    int n = 0;
    while (bus.dl_wait && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      compared++; mismatched++;
      $display("FAIL dl_wait_timeout: dl_wait still %b, required 0", bus.dl_wait);
    end
    bus.dl_wr = 1'b1;
    bus.dl_addr = a;
    bus.dl_data = d;
    tick();
    bus.dl_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.fsm_state !== ST_IDLE || bus.dl_wait) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      compared++; mismatched++;
      $display("FAIL idle_timeout: state %0d, required %0d", bus.fsm_state, ST_IDLE);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.core_valid && n < 500);
    if (n >= 500) begin
      compared++; mismatched++;
      $display("FAIL core_valid_timeout: core_valid %b, required 1", bus.core_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_dut();
    compared++; if (bus.fsm_state !== ST_IDLE) begin mismatched++; $display("FAIL rst_state: got %0d, required 0", bus.fsm_state); end
    compared++; if (bus.dl_wait !== 1'b0) begin mismatched++; $display("FAIL rst_dl_wait: got %b, required 0", bus.dl_wait); end
    compared++; if (bus.core_valid !== 1'b0) begin mismatched++; $display("FAIL rst_core_valid: got %b, required 0", bus.core_valid); end
    compared++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) begin mismatched++; $display("FAIL rst_strobes: got %b, required 00", {bus.mem_rd, bus.mem_wr}); end
    compared++; if (bus.mem_addr !== 25'h0) begin mismatched++; $display("FAIL rst_mem_addr: got %h, required 0", bus.mem_addr); end
    compared++; if (bus.core_dout !== 8'h00) begin mismatched++; $display("FAIL rst_core_dout: got %h, required 00", bus.core_dout); end
    compared++; if (bus.rom_mask !== 19'h7FFFF) begin mismatched++; $display("FAIL rst_rom_mask: got %h, required 7ffff", bus.rom_mask); end
  endtask

  task automatic test_download();
    logic [ADDR_W+7:0] exp_q[$];
    int base, w0, n;
    busy_len = 4;
    base = obs_q.size();
    w0 = wr_cnt;
    bus.dl_active = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      dl_write(ADDR_W'(i), 8'h10 + 8'(i));
      exp_q.push_back({ADDR_W'(i), 8'h10 + 8'(i)});
      compared++; if (bus.dl_wait !== 1'b1) begin mismatched++; $display("FAIL dl_wait_capture%0d: got %b, required 1", i, bus.dl_wait); end
      n = 0;
      while (bus.dl_wait && n < 50) begin tick(); n++; end
      // capture -> IDLE, WR_ISSUE, 2 guard cycles, 2 busy cycles in WAIT_DONE
      compared++; if (n !== 6) begin mismatched++; $display("FAIL dl_wait_len%0d: got %0d cycles, required 6", i, n); end
      compared++; if (bus.fsm_state !== ST_IDLE) begin mismatched++; $display("FAIL dl_wait_drop_state%0d: got %0d, required 0", i, bus.fsm_state); end
    end
    compared++; if (wr_cnt - w0 !== 3) begin mismatched++; $display("FAIL dl_wr_count: got %0d, required 3", wr_cnt - w0); end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (obs_q.size() <= base + i || obs_q[base + i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL dl_wr_data%0d: got %h, required %h", i, (obs_q.size() > base + i) ? obs_q[base + i] : '0, exp_q[i]);
      end
    end
    bus.dl_active = 1'b0;
    ticks(3);
    compared++; if (bus.rom_mask !== 19'h00003) begin mismatched++; $display("FAIL mask_3bytes: got %h, required 00003", bus.rom_mask); end
  endtask

  task automatic test_mask_boundary();
    bus.dl_active = 1'b1;
    tick();
    dl_write(25'h0, 8'h01);
    dl_write(25'h7FFFF, 8'h02);
    wait_idle();
    bus.dl_active = 1'b0;
    ticks(3);
    compared++; if (bus.rom_mask !== 19'h7FFFF) begin mismatched++; $display("FAIL mask_7ffff: got %h, required 7ffff", bus.rom_mask); end
    bus.dl_active = 1'b1;
    tick();
    dl_write(25'h01000, 8'h03);
    dl_write(25'h20000, 8'h04);
    wait_idle();
    bus.dl_active = 1'b0;
    ticks(3);
    compared++; if (bus.rom_mask !== 19'h3FFFF) begin mismatched++; $display("FAIL mask_20000: got %h, required 3ffff", bus.rom_mask); end
    bus.dl_active = 1'b1;
    ticks(2);
    bus.dl_active = 1'b0;
    ticks(3);
    compared++; if (bus.rom_mask !== 19'h3FFFF) begin mismatched++; $display("FAIL mask_empty_dl: got %h, required 3ffff", bus.rom_mask); end
  endtask

  task automatic test_read_cache();
    int r0, v0, n;
    busy_len = 3;
    rd_value = 8'hA5;
    r0 = rd_cnt;
    v0 = valid_cnt;
    bus.core_addr = 20'hC1234;
    bus.core_rd = 1'b1;
    wait_valid(n);
    bus.core_rd = 1'b0;
    // strobe, 2 guard cycles, busy already low in WAIT_DONE, then the valid cycle
    compared++; if (n !== 5) begin mismatched++; $display("FAIL rd_latency: got %0d cycles, required 5", n); end
    compared++; if (bus.core_dout !== 8'hA5) begin mismatched++; $display("FAIL rd_dout: got %h, required a5", bus.core_dout); end
    compared++; if (last_rd_addr !== 25'h01234) begin mismatched++; $display("FAIL rd_mem_addr: got %h, required 0001234", last_rd_addr); end
    ticks(3);
    compared++; if (valid_cnt - v0 !== 1) begin mismatched++; $display("FAIL rd_valid_pulses: got %0d, required 1", valid_cnt - v0); end
    rd_value = 8'h5A;
    bus.core_rd = 1'b1;
    tick();
    compared++; if (bus.core_valid !== 1'b1) begin mismatched++; $display("FAIL hit_valid: got %b, required 1", bus.core_valid); end
    compared++; if (bus.core_dout !== 8'hA5) begin mismatched++; $display("FAIL hit_dout: got %h, required a5", bus.core_dout); end
    bus.core_rd = 1'b0;
    ticks(3);
    compared++; if (rd_cnt - r0 !== 1) begin mismatched++; $display("FAIL hit_no_mem_rd: got %0d reads, required 1", rd_cnt - r0); end
  endtask

  task automatic test_dl_blocks_read();
    int r0, v0, n;
    r0 = rd_cnt;
    v0 = valid_cnt;
    bus.core_addr = 20'hC1234;
    bus.dl_active = 1'b1;
    bus.core_rd = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) dl_write(ADDR_W'(i), 8'h20 + 8'(i));
    wait_idle();
    ticks(2);
    compared++; if (rd_cnt - r0 !== 0) begin mismatched++; $display("FAIL dl_block_rd: got %0d reads, required 0", rd_cnt - r0); end
    compared++; if (valid_cnt - v0 !== 0) begin mismatched++; $display("FAIL dl_block_valid: got %0d pulses, required 0", valid_cnt - v0); end
    rd_value = 8'h3C;
    bus.dl_active = 1'b0;
    wait_valid(n);
    bus.core_rd = 1'b0;
    compared++; if (bus.core_dout !== 8'h3C) begin mismatched++; $display("FAIL post_dl_dout: got %h, required 3c", bus.core_dout); end
    compared++; if (rd_cnt - r0 !== 1) begin mismatched++; $display("FAIL post_dl_miss: got %0d reads, required 1", rd_cnt - r0); end
    // new mask 3: 0xC1234 & 3 = 0
    compared++; if (last_rd_addr !== 25'h0) begin mismatched++; $display("FAIL post_dl_addr: got %h, required 0000000", last_rd_addr); end
    compared++; if (bus.rom_mask !== 19'h00003) begin mismatched++; $display("FAIL post_dl_mask: got %h, required 00003", bus.rom_mask); end
  endtask

  task automatic test_write_priority();
    int r0, w0, base, n;
    r0 = rd_cnt;
    w0 = wr_cnt;
    base = obs_q.size();
    rd_value = 8'h77;
    bus.core_addr = 20'h00002;
    bus.core_rd = 1'b1;
    bus.dl_wr = 1'b1;
    bus.dl_addr = 25'h00100;
    bus.dl_data = 8'hEE;
    tick();
    bus.dl_wr = 1'b0;
    wait_valid(n);
    bus.core_rd = 1'b0;
    compared++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin mismatched++; $display("FAIL prio_counts: got %0d wr %0d rd, required 1 1", wr_cnt - w0, rd_cnt - r0); end
    compared++; if (!(wr_time < rd_time)) begin mismatched++; $display("FAIL prio_order: write at %0d read at %0d, required write first", wr_time, rd_time); end
    compared++;
    if (obs_q.size() <= base || obs_q[base] !== {25'h00100, 8'hEE}) begin
      mismatched++;
      $display("FAIL prio_wr_data: got %h, required %h", (obs_q.size() > base) ? obs_q[base] : '0, {25'h00100, 8'hEE});
    end
    compared++; if (bus.core_dout !== 8'h77 || last_rd_addr !== 25'h2) begin mismatched++; $display("FAIL prio_rd: got %h @%h, required 77 @0000002", bus.core_dout, last_rd_addr); end
  endtask

  task automatic test_reset_mid();
    int r0, n;
    busy_len = 20;
    bus.core_addr = 20'h00003;
    bus.core_rd = 1'b1;
    n = 0;
    while (bus.fsm_state !== ST_WAIT && n < 50) begin tick(); n++; end
    compared++; if (bus.fsm_state !== ST_WAIT) begin mismatched++; $display("FAIL mid_reach_wait: got %0d, required 4", bus.fsm_state); end
    r0 = rd_cnt;
    rst = 1'b1;
    #1;
    compared++; if (bus.fsm_state !== ST_IDLE) begin mismatched++; $display("FAIL mid_rst_state: got %0d, required 0", bus.fsm_state); end
    compared++; if (bus.rom_mask !== 19'h7FFFF) begin mismatched++; $display("FAIL mid_rst_mask: got %h, required 7ffff", bus.rom_mask); end
    compared++; if ({bus.dl_wait, bus.core_valid, bus.mem_rd, bus.mem_wr} !== 4'b0000) begin mismatched++; $display("FAIL mid_rst_ctrl: got %b, required 0000", {bus.dl_wait, bus.core_valid, bus.mem_rd, bus.mem_wr}); end
    compared++; if (bus.mem_addr !== 25'h0 || bus.core_dout !== 8'h00 || bus.mem_din !== 8'h00) begin mismatched++; $display("FAIL mid_rst_data: got %h %h %h, required 0 0 0", bus.mem_addr, bus.core_dout, bus.mem_din); end
    bus.core_rd = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(10);
    compared++; if (rd_cnt - r0 !== 0 || wr_cnt < 0) begin mismatched++; $display("FAIL mid_no_reissue: got %0d reads, required 0", rd_cnt - r0); end
    compared++; if (proto_err !== 0) begin mismatched++; $display("FAIL strobe_protocol: got %0d violations, required 0", proto_err); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_download();
    test_mask_boundary();
    test_read_cache();
    test_dl_blocks_read();
    test_write_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
